// File: rtl/button_event_reader.sv
// Push-button front end: per-pin synchroniser, debounce and press/release/long-press
// detection, feeding a one-deep valid/ready event register from per-button pending flags.
module button_event_reader #(
  parameter int NUM_BTN         = 6,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 3000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_code,
  output logic [2:0]         evt_idx,
  output logic               evt_overflow
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]    DB_ZERO   = {DB_W{1'b0}};
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [NUM_BTN-1:0] PINS_IDLE = {NUM_BTN{ACTIVE_LOW}};
  localparam logic [NUM_BTN-1:0] NONE      = {NUM_BTN{1'b0}};

  localparam logic [1:0] CODE_PRESS   = 2'b00;
  localparam logic [1:0] CODE_RELEASE = 2'b01;
  localparam logic [1:0] CODE_LONG    = 2'b10;

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;
  logic [NUM_BTN-1:0] level_r;
  logic [DB_W-1:0]    db_cnt_r   [NUM_BTN];
  logic [HOLD_W-1:0]  hold_cnt_r [NUM_BTN];

  logic [NUM_BTN-1:0] press_pend_r;
  logic [NUM_BTN-1:0] rel_pend_r;
  logic [NUM_BTN-1:0] long_pend_r;
  logic               overflow_r;

  logic               evt_valid_r;
  logic [1:0]         evt_code_r;
  logic [2:0]         evt_idx_r;

  logic [NUM_BTN-1:0] pressed_s;
  logic [NUM_BTN-1:0] toggle_s;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] fall_s;
  logic [NUM_BTN-1:0] long_hit_s;

  logic               load_s;
  logic               sel_found_s;
  logic [2:0]         sel_idx_s;
  logic [1:0]         sel_code_s;
  logic [NUM_BTN-1:0] clr_press_s;
  logic [NUM_BTN-1:0] clr_rel_s;
  logic [NUM_BTN-1:0] clr_long_s;
  logic [NUM_BTN-1:0] press_nx_s;
  logic [NUM_BTN-1:0] rel_nx_s;
  logic [NUM_BTN-1:0] long_nx_s;
  logic               ovf_hit_s;

  assign btn_level    = level_r;
  assign evt_valid    = evt_valid_r;
  assign evt_code     = evt_code_r;
  assign evt_idx      = evt_idx_r;
  assign evt_overflow = overflow_r;

  // Debounce decode: accept a new level, and raise long-press, per button
  always_comb begin
    pressed_s  = sync2_r ^ PINS_IDLE;
    toggle_s   = NONE;
    long_hit_s = NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      toggle_s[i]   = (pressed_s[i] != level_r[i]) && (db_cnt_r[i] == DB_LAST);
      // A press that is being released this cycle never earns a long event
      long_hit_s[i] = level_r[i] && !toggle_s[i] && (hold_cnt_r[i] == HOLD_LAST);
    end
    rise_s = toggle_s & ~level_r;
    fall_s = toggle_s & level_r;
  end

  // Event selection: lowest index wins, then press > long > release
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 3'd0;
    sel_code_s  = CODE_PRESS;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_pend_r[i] || long_pend_r[i] || rel_pend_r[i]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = 3'(i);
        if (press_pend_r[i]) begin
          sel_code_s = CODE_PRESS;
        end else if (long_pend_r[i]) begin
          sel_code_s = CODE_LONG;
        end else begin
          sel_code_s = CODE_RELEASE;
        end
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Pending-flag update: clear the issued flag, new sets take priority
  always_comb begin
    load_s      = !evt_valid_r || evt_ready;
    clr_press_s = NONE;
    clr_rel_s   = NONE;
    clr_long_s  = NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (load_s && sel_found_s && (sel_idx_s == 3'(i))) begin
        case (sel_code_s)
          CODE_PRESS:   clr_press_s[i] = 1'b1;
          CODE_LONG:    clr_long_s[i]  = 1'b1;
          CODE_RELEASE: clr_rel_s[i]   = 1'b1;
          default:      clr_press_s[i] = 1'b0;
        endcase
      end else begin
        clr_press_s[i] = 1'b0;
      end
    end
    press_nx_s = (press_pend_r & ~clr_press_s) | rise_s;
    rel_nx_s   = (rel_pend_r   & ~clr_rel_s)   | fall_s;
    long_nx_s  = (long_pend_r  & ~clr_long_s)  | long_hit_s;
    ovf_hit_s  = |((rise_s     & press_pend_r & ~clr_press_s) |
                   (fall_s     & rel_pend_r   & ~clr_rel_s)   |
                   (long_hit_s & long_pend_r  & ~clr_long_s));
  end

  // Two-flop synchroniser, reset to the released pin level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= PINS_IDLE;
      sync2_r <= PINS_IDLE;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce and hold counters with the accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_r <= NONE;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_r[i]   <= DB_ZERO;
        hold_cnt_r[i] <= HOLD_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (toggle_s[i]) begin
          level_r[i]  <= ~level_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else if (pressed_s[i] != level_r[i]) begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end else begin
          db_cnt_r[i] <= DB_ZERO;
        end

        // Saturating hold count gives exactly one long event per press
        if (fall_s[i]) begin
          hold_cnt_r[i] <= HOLD_ZERO;
        end else if (level_r[i] && (hold_cnt_r[i] != HOLD_MAX)) begin
          hold_cnt_r[i] <= hold_cnt_r[i] + HOLD_ONE;
        end else begin
          hold_cnt_r[i] <= hold_cnt_r[i];
        end
      end
    end
  end

  // Pending flags and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_pend_r <= NONE;
      rel_pend_r   <= NONE;
      long_pend_r  <= NONE;
      overflow_r   <= 1'b0;
    end else begin
      press_pend_r <= press_nx_s;
      rel_pend_r   <= rel_nx_s;
      long_pend_r  <= long_nx_s;
      overflow_r   <= overflow_r | ovf_hit_s;
    end
  end

  // Output event register; held stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid_r <= 1'b0;
      evt_code_r  <= CODE_PRESS;
      evt_idx_r   <= 3'd0;
    end else if (load_s) begin
      evt_valid_r <= sel_found_s;
      if (sel_found_s) begin
        evt_code_r <= sel_code_s;
        evt_idx_r  <= sel_idx_s;
      end else begin
        evt_code_r <= evt_code_r;
        evt_idx_r  <= evt_idx_r;
      end
    end else begin
      evt_valid_r <= evt_valid_r;
      evt_code_r  <= evt_code_r;
      evt_idx_r   <= evt_idx_r;
    end
  end

endmodule

// File: tb/tb_button_event_reader.sv
// Directed bench for button_event_reader with short debounce/long-press timings.
module tb_button_event_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btn_in;
  logic [5:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [2:0] evt_idx;
  logic       evt_overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [1:0] q_code[$];
  logic [2:0] q_idx[$];
  int         q_cyc[$];

  always #5 clk = ~clk;

  button_event_reader #(
    .NUM_BTN(6),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_idx(evt_idx),
    .evt_overflow(evt_overflow)
  );

  // Advance one clock; log the event that the next edge will accept
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (evt_valid && evt_ready) begin
      q_code.push_back(evt_code);
      q_idx.push_back(evt_idx);
      q_cyc.push_back(cyc);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_log();
    q_code.delete();
    q_idx.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_in = 6'b111111; evt_ready = 1'b1;
    ticks(2);
    checks++;
    if ({btn_level, evt_valid, evt_code, evt_idx, evt_overflow} !== 13'b0)
      begin errors++; $display("FAIL reset_outputs: got %b expected %b",
        {btn_level, evt_valid, evt_code, evt_idx, evt_overflow}, 13'b0); end
    rst_n = 1'b1;
    ticks(8);
    checks++;
    if ({btn_level, evt_valid} !== 7'b0)
      begin errors++; $display("FAIL reset_idle: got %b expected %b", {btn_level, evt_valid}, 7'b0); end
  endtask

  task automatic test_press_release();
    clear_log();
    btn_in[2] = 1'b0;
    ticks(5);
    checks++;
    if (btn_level !== 6'b000000)
      begin errors++; $display("FAIL t1_level_early: got %b expected %b", btn_level, 6'b000000); end
    tick();
    checks++;
    if (btn_level !== 6'b000100)
      begin errors++; $display("FAIL t1_level_rise: got %b expected %b", btn_level, 6'b000100); end
    checks++;
    if (evt_valid !== 1'b0)
      begin errors++; $display("FAIL t1_valid_same_cycle: got %b expected 0", evt_valid); end
    tick();
    checks++;
    if ({evt_valid, evt_code, evt_idx} !== {1'b1, 2'b00, 3'd2})
      begin errors++; $display("FAIL t1_press_evt: got %b expected %b",
        {evt_valid, evt_code, evt_idx}, {1'b1, 2'b00, 3'd2}); end
    ticks(3);
    btn_in[2] = 1'b1;
    ticks(5);
    checks++;
    if (btn_level !== 6'b000100)
      begin errors++; $display("FAIL t1_level_hold: got %b expected %b", btn_level, 6'b000100); end
    tick();
    checks++;
    if (btn_level !== 6'b000000)
      begin errors++; $display("FAIL t1_level_fall: got %b expected %b", btn_level, 6'b000000); end
    tick();
    checks++;
    if ({evt_valid, evt_code, evt_idx} !== {1'b1, 2'b01, 3'd2})
      begin errors++; $display("FAIL t1_release_evt: got %b expected %b",
        {evt_valid, evt_code, evt_idx}, {1'b1, 2'b01, 3'd2}); end
    ticks(25);
    checks++;
    if (q_code.size() !== 2 || evt_valid !== 1'b0)
      begin errors++; $display("FAIL t1_no_long: got %0d events valid=%b expected 2 events valid=0",
        q_code.size(), evt_valid); end
  endtask

  task automatic test_glitch();
    clear_log();
    btn_in[3] = 1'b0; ticks(3);
    btn_in[3] = 1'b1; tick();
    btn_in[3] = 1'b0; ticks(3);
    btn_in[3] = 1'b1; ticks(10);
    checks++;
    if (btn_level !== 6'b000000)
      begin errors++; $display("FAIL t2_level: got %b expected %b", btn_level, 6'b000000); end
    checks++;
    if (q_code.size() !== 0 || evt_valid !== 1'b0)
      begin errors++; $display("FAIL t2_no_event: got %0d events valid=%b expected 0 events valid=0",
        q_code.size(), evt_valid); end
  endtask

  task automatic test_long_press();
    int start;
    logic [1:0] exp_code [3];
    int         exp_off  [3];
    exp_code[0] = 2'b00; exp_off[0] = 7;
    exp_code[1] = 2'b10; exp_off[1] = 27;
    exp_code[2] = 2'b01; exp_off[2] = 47;
    clear_log();
    start = cyc;
    btn_in[0] = 1'b0; ticks(40);
    btn_in[0] = 1'b1; ticks(20);
    checks++;
    if (q_code.size() !== 3)
      begin errors++; $display("FAIL t3_event_count: got %0d expected 3", q_code.size()); end
    else begin
      for (int e = 0; e < 3; e++) begin
        checks++;
        if ({q_code[e], q_idx[e]} !== {exp_code[e], 3'd0} || q_cyc[e] !== start + exp_off[e])
          begin errors++; $display("FAIL t3_event%0d: got code=%b idx=%0d cyc=%0d expected code=%b idx=0 cyc=%0d",
            e, q_code[e], q_idx[e], q_cyc[e] - start, exp_code[e], exp_off[e]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    evt_ready = 1'b0;
    btn_in[1] = 1'b0; btn_in[4] = 1'b0;
    ticks(7);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({evt_valid, evt_code, evt_idx} !== {1'b1, 2'b00, 3'd1})
        begin errors++; $display("FAIL t4_stall_hold%0d: got %b expected %b", k,
          {evt_valid, evt_code, evt_idx}, {1'b1, 2'b00, 3'd1}); end
      if (k < 9) tick();
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if ({evt_valid, evt_code, evt_idx} !== {1'b1, 2'b00, 3'd4})
      begin errors++; $display("FAIL t4_next_evt: got %b expected %b",
        {evt_valid, evt_code, evt_idx}, {1'b1, 2'b00, 3'd4}); end
    tick();
    checks++;
    if (evt_valid !== 1'b0)
      begin errors++; $display("FAIL t4_drained: got %b expected 0", evt_valid); end
    btn_in[1] = 1'b1; btn_in[4] = 1'b1;
    ticks(12);
    checks++;
    if (q_code.size() !== 3)
      begin errors++; $display("FAIL t4_event_count: got %0d expected 3", q_code.size()); end
    else begin
      checks++;
      if ({q_code[1], q_idx[1], q_code[2], q_idx[2]} !== {2'b01, 3'd1, 2'b01, 3'd4})
        begin errors++; $display("FAIL t4_release_order: got %b expected %b",
          {q_code[1], q_idx[1], q_code[2], q_idx[2]}, {2'b01, 3'd1, 2'b01, 3'd4}); end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    evt_ready = 1'b0;
    btn_in[0] = 1'b0; ticks(8);
    btn_in[0] = 1'b1; ticks(8);
    btn_in[5] = 1'b0; ticks(8);
    btn_in[5] = 1'b1; ticks(8);
    btn_in[5] = 1'b0; ticks(5);
    checks++;
    if (evt_overflow !== 1'b0)
      begin errors++; $display("FAIL t5_ovf_early: got %b expected 0", evt_overflow); end
    tick();
    checks++;
    if (evt_overflow !== 1'b1)
      begin errors++; $display("FAIL t5_ovf_set: got %b expected 1", evt_overflow); end
    ticks(2);
    btn_in[5] = 1'b1; ticks(10);
    checks++;
    if ({evt_valid, evt_code, evt_idx, evt_overflow} !== {1'b1, 2'b00, 3'd0, 1'b1})
      begin errors++; $display("FAIL t5_held: got %b expected %b",
        {evt_valid, evt_code, evt_idx, evt_overflow}, {1'b1, 2'b00, 3'd0, 1'b1}); end
    evt_ready = 1'b1;
    clear_log();
    ticks(10);
    checks++;
    if (q_code.size() !== 3)
      begin errors++; $display("FAIL t5_event_count: got %0d expected 3", q_code.size()); end
    else begin
      checks++;
      if ({q_code[0], q_idx[0], q_code[1], q_idx[1], q_code[2], q_idx[2]} !==
          {2'b01, 3'd0, 2'b00, 3'd5, 2'b01, 3'd5})
        begin errors++; $display("FAIL t5_events: got %b expected %b",
          {q_code[0], q_idx[0], q_code[1], q_idx[1], q_code[2], q_idx[2]},
          {2'b01, 3'd0, 2'b00, 3'd5, 2'b01, 3'd5}); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    evt_ready = 1'b0;
    btn_in[1] = 1'b0; ticks(8);
    checks++;
    if ({evt_valid, evt_code, evt_idx} !== {1'b1, 2'b00, 3'd1})
      begin errors++; $display("FAIL t6_before_reset: got %b expected %b",
        {evt_valid, evt_code, evt_idx}, {1'b1, 2'b00, 3'd1}); end
    rst_n = 1'b0; ticks(2);
    checks++;
    if ({btn_level, evt_valid, evt_code, evt_idx, evt_overflow} !== 13'b0)
      begin errors++; $display("FAIL t6_reset_outputs: got %b expected %b",
        {btn_level, evt_valid, evt_code, evt_idx, evt_overflow}, 13'b0); end
    rst_n = 1'b1; ticks(5);
    checks++;
    if (btn_level !== 6'b000000)
      begin errors++; $display("FAIL t6_level_early: got %b expected %b", btn_level, 6'b000000); end
    tick();
    checks++;
    if (btn_level !== 6'b000010)
      begin errors++; $display("FAIL t6_level_rise: got %b expected %b", btn_level, 6'b000010); end
    evt_ready = 1'b1;
    tick();
    checks++;
    if ({evt_valid, evt_code, evt_idx} !== {1'b1, 2'b00, 3'd1})
      begin errors++; $display("FAIL t6_repress_evt: got %b expected %b",
        {evt_valid, evt_code, evt_idx}, {1'b1, 2'b00, 3'd1}); end
    btn_in[1] = 1'b1; ticks(15);
    checks++;
    if ({btn_level, evt_valid} !== 7'b0 || q_code.size() !== 2)
      begin errors++; $display("FAIL t6_final: got level/valid=%b events=%0d expected 0 and 2 events",
        {btn_level, evt_valid}, q_code.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_in = 6'b111111;
    evt_ready = 1'b1;
    test_reset();
    test_press_release();
    test_glitch();
    test_long_press();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
